// File: rtl/ad9854_par_writer.sv
// ad9854_par_writer: latches a DDS register image on a CEN rising edge and writes it
// byte by byte over the AD9854 parallel port, then pulses the I/O update line.
module ad9854_par_writer #(
  parameter int WR_SETUP = 2,
  parameter int WR_LOW   = 3,
  parameter int WR_HOLD  = 2,
  parameter int UD_WIDTH = 8
) (
  input  logic        CLKIN,
  input  logic        RSTN,
  input  logic        CEN,
  input  logic [15:0] F1H,
  input  logic [31:0] F1L,
  input  logic [15:0] F2H,
  input  logic [31:0] F2L,
  input  logic [13:0] PTW1,
  input  logic [13:0] PTW2,
  input  logic [47:0] DFW,
  input  logic [19:0] RAMPRATE,
  input  logic [2:0]  MODE,
  input  logic        TRAIANGLE,
  input  logic        PLLEN,
  input  logic [4:0]  CLKMUILT,
  input  logic        PLLRANGE,
  output logic [5:0]  DDS_ADDR,
  output logic [7:0]  DDS_DATA,
  output logic        DDS_WRB,
  output logic        DDS_UDCLK,
  output logic        BUSY,
  output logic        DONE
);
  localparam logic [7:0] SETUP_LAST  = 8'(WR_SETUP - 1);
  localparam logic [7:0] STROBE_LAST = 8'(WR_LOW - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(WR_HOLD - 1);
  localparam logic [7:0] UPD_LAST    = 8'(UD_WIDTH - 1);
  localparam logic [4:0] LAST_BYTE   = 5'd26;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, UPD, FIN} state_t;
  state_t       state, next;
  logic [7:0]   cnt;
  logic [4:0]   idx;
  logic         cen_q, pending, cen_rise, start;
  logic [215:0] img, new_img;
  // Full write list in transmit order, first byte in the top bits.
  assign new_img = {1'b0, PLLRANGE, PLLEN, CLKMUILT,
                    2'b00, TRAIANGLE, 1'b0, MODE, 1'b0,
                    2'b00, PTW1, 2'b00, PTW2,
                    F1H, F1L, F2H, F2L, DFW,
                    4'h0, RAMPRATE};
  assign cen_rise = CEN & ~cen_q;
  assign start    = cen_rise | pending;
  function automatic logic [5:0] addr_of(input logic [4:0] i);
    return (i == 5'd0) ? 6'h1E :
           (i == 5'd1) ? 6'h1F :
           (i < 5'd24) ? 6'(i - 5'd2) : 6'(i + 5'd2);
  endfunction
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? SETUP : IDLE;
      SETUP:   next = (cnt == SETUP_LAST) ? STROBE : SETUP;
      STROBE:  next = (cnt == STROBE_LAST) ? HOLD : STROBE;
      HOLD:    next = (cnt != HOLD_LAST) ? HOLD : (idx == LAST_BYTE) ? UPD : SETUP;
      UPD:     next = (cnt == UPD_LAST) ? FIN : UPD;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge CLKIN or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      cen_q     <= 1'b0;
      pending   <= 1'b0;
      img       <= '0;
      DDS_ADDR  <= '0;
      DDS_DATA  <= '0;
      DDS_WRB   <= 1'b1;
      DDS_UDCLK <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= next;
      cen_q     <= CEN;
      cnt       <= (next != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
      pending   <= (state == IDLE) ? 1'b0 : pending | cen_rise;
      // Outputs are registered from the next state so the pins never glitch.
      DDS_WRB   <= (next != STROBE);
      DDS_UDCLK <= (next == UPD);
      BUSY      <= (next != IDLE);
      DONE      <= (next == FIN);
      if (state == IDLE && next == SETUP) begin
        img      <= new_img;
        idx      <= 5'd0;
        DDS_ADDR <= addr_of(5'd0);
        DDS_DATA <= new_img[215:208];
      end else if (state == HOLD && next == SETUP) begin
        img      <= {img[207:0], 8'h00};
        idx      <= idx + 5'd1;
        DDS_ADDR <= addr_of(idx + 5'd1);
        DDS_DATA <= img[207:200];
      end
    end
  end
endmodule
